// File: rtl/des_subkey_sequencer.sv
//------------------------------------------------------------------------------
// des_subkey_sequencer
//
// Streams the sixteen 48-bit DES round subkeys for one 64-bit key, one per
// handshake. The default order is decryption order (K16 first, K1 last).
// It walks the C/D halves backwards by rotating right. K16 is taken straight
// from PC-1 of the key, because the full shift schedule adds up to 28 and so
// returns C/D to their starting value.
//
// Optional build macro:
//   DES_ENCRYPT_ORDER_EN - adds the 'decrypt' input, which is sampled when a
//                          key is accepted. decrypt=0 selects encryption
//                          order (K1 first, left rotation). decrypt=1 keeps
//                          decryption order.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   key_valid / key_ready key input handshake (ready only while idle)
//   key[1:64]             DES key, bit 1 = MSB; parity bits are never used
//   decrypt               (macro only) order select, sampled at key accept
//   sk_valid / sk_ready   subkey output handshake, full backpressure
//   subkey[1:48]          PC-2 of the current C/D registers
//   sk_round[4:0]         round number of the presented subkey, 0 when idle
//   sk_last               presented subkey is the final one of the sequence
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module des_subkey_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic [1:64] key,
`ifdef DES_ENCRYPT_ORDER_EN
  input  logic        decrypt,
`endif
  output logic        sk_valid,
  input  logic        sk_ready,
  output logic [1:48] subkey,
  output logic [4:0]  sk_round,
  output logic        sk_last
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [1:28] c_q, c_d;
  logic [1:28] d_q, d_d;
  logic [4:0]  round_q, round_d;
  logic        last_q, last_d;
  logic        dec_q, dec_d;

  logic [1:28] c0, d0;     // PC-1 halves of the incoming key (C0 / D0)
  logic [1:56] cd;         // current {C,D} feeding PC-2
  logic        load_dec;   // order requested for the key being accepted

`ifdef DES_ENCRYPT_ORDER_EN
  assign load_dec = decrypt;
`else
  assign load_dec = 1'b1;
`endif

  //----------------------------------------------------------------------------
  // Fixed DES tables
  //----------------------------------------------------------------------------

  // PC-1, left half (C0). The parity bits 8,16,...,64 never appear.
  assign c0 = {key[57], key[49], key[41], key[33], key[25], key[17], key[ 9],
               key[ 1], key[58], key[50], key[42], key[34], key[26], key[18],
               key[10], key[ 2], key[59], key[51], key[43], key[35], key[27],
               key[19], key[11], key[ 3], key[60], key[52], key[44], key[36]};

  // PC-1, right half (D0).
  assign d0 = {key[63], key[55], key[47], key[39], key[31], key[23], key[15],
               key[ 7], key[62], key[54], key[46], key[38], key[30], key[22],
               key[14], key[ 6], key[61], key[53], key[45], key[37], key[29],
               key[21], key[13], key[ 5], key[28], key[20], key[12], key[ 4]};

  assign cd = {c_q, d_q};

  // PC-2 compresses the 56-bit {C,D} into the 48-bit round subkey. It is
  // driven only from registers, so the subkey stays stable during a stall.
  assign subkey = {cd[14], cd[17], cd[11], cd[24], cd[ 1], cd[ 5],
                   cd[ 3], cd[28], cd[15], cd[ 6], cd[21], cd[10],
                   cd[23], cd[19], cd[12], cd[ 4], cd[26], cd[ 8],
                   cd[16], cd[ 7], cd[27], cd[20], cd[13], cd[ 2],
                   cd[41], cd[52], cd[31], cd[37], cd[47], cd[55],
                   cd[30], cd[40], cd[51], cd[45], cd[33], cd[48],
                   cd[44], cd[49], cd[39], cd[56], cd[34], cd[53],
                   cd[46], cd[42], cd[50], cd[36], cd[29], cd[32]};

  //----------------------------------------------------------------------------
  // Helpers
  //----------------------------------------------------------------------------

  // Rounds 1, 2, 9 and 16 shift by one position. All other rounds shift by two.
  function automatic logic single_shift(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd2) || (r == 5'd9) || (r == 5'd16);
  endfunction

  // Left rotation moves bit 2 into bit 1, toward the MSB end.
  function automatic logic [1:28] rot_l(input logic [1:28] x, input logic by_one);
    return by_one ? {x[2:28], x[1]} : {x[3:28], x[1:2]};
  endfunction

  // Right rotation undoes rot_l. Applying it to C_r by s(r) gives C_(r-1).
  function automatic logic [1:28] rot_r(input logic [1:28] x, input logic by_one);
    return by_one ? {x[28], x[1:27]} : {x[27:28], x[1:26]};
  endfunction

  //----------------------------------------------------------------------------
  // Next-state logic
  //----------------------------------------------------------------------------
  // NOTE: every signal this block writes gets a default first. A path that
  // does not assign a signal then holds its value, and no latch is inferred.
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    round_d = round_q;
    last_d  = last_q;
    dec_d   = dec_q;

    unique case (state_q)
      S_IDLE: begin
        if (key_valid) begin
          state_d = S_EMIT;
          dec_d   = load_dec;
          last_d  = 1'b0;
          if (load_dec) begin
            // C16/D16 equals C0/D0, so K16 is presented straight away.
            c_d     = c0;
            d_d     = d0;
            round_d = 5'd16;
          end else begin
            // Encryption order starts at C1/D1 (s(1) = 1).
            c_d     = rot_l(c0, 1'b1);
            d_d     = rot_l(d0, 1'b1);
            round_d = 5'd1;
          end
        end
      end

      S_EMIT: begin
        if (sk_ready) begin
          if (last_q) begin
            // C/D are left as they are. Only the visible status is cleared.
            state_d = S_IDLE;
            round_d = 5'd0;
            last_d  = 1'b0;
          end else if (dec_q) begin
            c_d     = rot_r(c_q, single_shift(round_q));
            d_d     = rot_r(d_q, single_shift(round_q));
            round_d = round_q - 5'd1;
            last_d  = (round_q == 5'd2);
          end else begin
            c_d     = rot_l(c_q, single_shift(round_q + 5'd1));
            d_d     = rot_l(d_q, single_shift(round_q + 5'd1));
            round_d = round_q + 5'd1;
            last_d  = (round_q == 5'd15);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  //----------------------------------------------------------------------------
  // State registers
  //----------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments. Every flop then
  // samples the pre-edge values, whatever order the statements are in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      c_q     <= '0;
      d_q     <= '0;
      round_q <= 5'd0;
      last_q  <= 1'b0;
      dec_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      round_q <= round_d;
      last_q  <= last_d;
      dec_q   <= dec_d;
    end
  end

  //----------------------------------------------------------------------------
  // Outputs (all taken straight from registers)
  //----------------------------------------------------------------------------
  assign key_ready = (state_q == S_IDLE);
  assign sk_valid  = (state_q == S_EMIT);
  assign sk_round  = round_q;
  assign sk_last   = last_q;

endmodule
